// File: rtl/predictor_update_ctrl_pkg.sv
// Shared definitions for the predictor update controller: outcome-entry layout
// and controller FSM encodings.
package predictor_update_ctrl_pkg;

  localparam int ENTRY_TAKEN = 0;
  localparam int ENTRY_MISS  = 1;
  localparam int ENTRY_W     = 2;

  typedef logic [ENTRY_W-1:0] entry_t;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_t;

  function automatic entry_t make_entry(input logic taken, input logic miss);
    entry_t e;
    e              = '0;
    e[ENTRY_TAKEN] = taken;
    e[ENTRY_MISS]  = miss;
    return e;
  endfunction

endpackage

// File: rtl/predictor_update_ctrl_if.sv
// Bundle of the ROB commit, PC insert and predictor update signals.
// master = the surrounding pipeline, slave = the update controller.
interface predictor_update_ctrl_if;

  logic rob_commit1_en;
  logic rob_commit1_taken;
  logic rob_commit1_miss;
  logic rob_commit2_en;
  logic rob_commit2_taken;
  logic rob_commit2_miss;
  logic rob_ready;

  logic pc_insert_req;
  logic pc_insert_mux;
  logic pc_stall;

  logic bp_insert_en;
  logic bp_mux;
  logic bp_modify_en;
  logic bp_clear;
  logic bp_choice;

  modport master (
    output rob_commit1_en, rob_commit1_taken, rob_commit1_miss,
    output rob_commit2_en, rob_commit2_taken, rob_commit2_miss,
    output pc_insert_req, pc_insert_mux,
    input  rob_ready, pc_stall,
    input  bp_insert_en, bp_mux, bp_modify_en, bp_clear, bp_choice
  );

  modport slave (
    input  rob_commit1_en, rob_commit1_taken, rob_commit1_miss,
    input  rob_commit2_en, rob_commit2_taken, rob_commit2_miss,
    input  pc_insert_req, pc_insert_mux,
    output rob_ready, pc_stall,
    output bp_insert_en, bp_mux, bp_modify_en, bp_clear, bp_choice
  );

endinterface

// File: rtl/predictor_update_ctrl_fifo.sv
// bp_update_fifo: dual-push, single-pop circular queue of branch outcomes.
// push1 is only used together with push0 (it lands one slot behind it).
module bp_update_fifo
  import predictor_update_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push0_en,
  input  entry_t                     push0_entry,
  input  logic                       push1_en,
  input  entry_t                     push1_entry,
  input  logic                       pop,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output entry_t                     head,
  output logic                       miss_pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   miss_cnt;
  logic [CNT_W-1:0]   n_push;
  logic [CNT_W-1:0]   n_miss_push;
  logic [CNT_W-1:0]   n_miss_pop;

  always_comb begin
    n_push      = CNT_W'(push0_en) + CNT_W'(push1_en);
    n_miss_push = CNT_W'(push0_en && push0_entry[ENTRY_MISS])
                + CNT_W'(push1_en && push1_entry[ENTRY_MISS]);
    n_miss_pop  = CNT_W'(pop && head[ENTRY_MISS]);
  end

  assign head         = mem[rd_ptr];
  assign miss_pending = (miss_cnt != '0);

  // NOTE: storage has no reset; count and pointers alone define which slots are valid.
  always_ff @(posedge clk) begin
    if (push0_en) mem[wr_ptr] <= push0_entry;
    if (push1_en) mem[wr_ptr + PTR_W'(1)] <= push1_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      miss_cnt <= '0;
    end else begin
      wr_ptr   <= wr_ptr + PTR_W'(n_push);
      rd_ptr   <= rd_ptr + PTR_W'(pop);
      count    <= count + n_push - CNT_W'(pop);
      miss_cnt <= miss_cnt + n_miss_push - n_miss_pop;
    end
  end

endmodule

// File: rtl/predictor_update_ctrl.sv
// Drains ROB branch outcomes into the predictor update port in commit order,
// sequences mispredict recovery and keeps retirement statistics.
module predictor_update_ctrl
  import predictor_update_ctrl_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int RECOVER_CYCLES = 2,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  predictor_update_ctrl_if.slave bus,
  output logic [CNT_WIDTH-1:0] stat_branches,
  output logic [CNT_WIDTH-1:0] stat_misses
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int RC_W  = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);
  localparam logic [RC_W-1:0]  RC_INIT   = RC_W'(RECOVER_CYCLES - 1);

  state_t            state, state_next;
  logic [RC_W-1:0]   rc_cnt, rc_next;
  logic [CNT_W-1:0]  count;
  entry_t            head;
  logic              miss_pending;

  logic   accept, c1, c2, pop;
  logic   push0_en, push1_en;
  entry_t e1, e2, push0_entry;

  // A mispredicted first commit kills the younger second one.
  assign accept = bus.rob_ready;
  assign c1     = accept && bus.rob_commit1_en;
  assign c2     = accept && bus.rob_commit2_en
               && !(bus.rob_commit1_en && bus.rob_commit1_miss);
  assign e1     = make_entry(bus.rob_commit1_taken, bus.rob_commit1_miss);
  assign e2     = make_entry(bus.rob_commit2_taken, bus.rob_commit2_miss);

  assign push0_en    = c1 || c2;
  assign push0_entry = c1 ? e1 : e2;
  assign push1_en    = c1 && c2;

  bp_update_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push0_en     (push0_en),
    .push0_entry  (push0_entry),
    .push1_en     (push1_en),
    .push1_entry  (e2),
    .pop          (pop),
    .count        (count),
    .head         (head),
    .miss_pending (miss_pending)
  );

  assign pop = rdy && (state == ST_RUN) && (count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RUN;
      rc_cnt <= '0;
    end else begin
      state  <= state_next;
      rc_cnt <= rc_next;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_next = state;
    rc_next    = rc_cnt;
    case (state)
      ST_RUN: begin
        if (pop && head[ENTRY_MISS]) begin
          state_next = ST_RECOVER;
          rc_next    = RC_INIT;
        end
      end
      ST_RECOVER: begin
        if (rdy) begin
          if (rc_cnt == '0) state_next = ST_RUN;
          else              rc_next    = rc_cnt - RC_W'(1);
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // Stall also covers the clear cycle and any miss still queued, so the PC
  // never inserts history that the pending restore would wipe out.
  assign bus.rob_ready    = rdy && (count <= READY_MAX);
  assign bus.bp_modify_en = pop;
  assign bus.bp_clear     = pop && head[ENTRY_MISS];
  assign bus.bp_choice    = pop && head[ENTRY_TAKEN];
  assign bus.pc_stall     = (state == ST_RECOVER) || bus.bp_clear || miss_pending;
  assign bus.bp_insert_en = rdy && bus.pc_insert_req && !bus.pc_stall;
  assign bus.bp_mux       = bus.pc_insert_mux;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches <= '0;
      stat_misses   <= '0;
    end else if (pop) begin
      stat_branches <= stat_branches + CNT_WIDTH'(1);
      if (head[ENTRY_MISS]) stat_misses <= stat_misses + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_predictor_update_ctrl.sv
// Scoreboard bench for predictor_update_ctrl: expected outcomes queued at
// commit time, compared as the predictor update port fires.
module tb_predictor_update_ctrl;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [31:0] stat_branches;
  logic [31:0] stat_misses;

  predictor_update_ctrl_if bus();

  predictor_update_ctrl #(
    .DEPTH          (4),
    .RECOVER_CYCLES (2),
    .CNT_WIDTH      (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .bus           (bus),
    .stat_branches (stat_branches),
    .stat_misses   (stat_misses)
  );

  typedef struct {
    logic taken;
    logic miss;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  task automatic idle();
    bus.rob_commit1_en    = 1'b0;
    bus.rob_commit1_taken = 1'b0;
    bus.rob_commit1_miss  = 1'b0;
    bus.rob_commit2_en    = 1'b0;
    bus.rob_commit2_taken = 1'b0;
    bus.rob_commit2_miss  = 1'b0;
  endtask

  // Drive one commit cycle; when the bench expects the ROB to be accepted,
  // queue the outcomes that must reach the predictor.
  task automatic commit(input logic c1e, input logic c1t, input logic c1m,
                        input logic c2e, input logic c2t, input logic c2m,
                        input bit accept);
    exp_t e;
    bus.rob_commit1_en    = c1e;
    bus.rob_commit1_taken = c1t;
    bus.rob_commit1_miss  = c1m;
    bus.rob_commit2_en    = c2e;
    bus.rob_commit2_taken = c2t;
    bus.rob_commit2_miss  = c2m;
    if (accept) begin
      if (c1e) begin
        e.taken = c1t; e.miss = c1m;
        exp_q.push_back(e);
      end
      if (c2e && !(c1e && c1m)) begin
        e.taken = c2t; e.miss = c2m;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  // Scoreboard: every predictor update must match the oldest expected outcome.
  always @(negedge clk) begin
    if (!rst && bus.bp_modify_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pop_choice", bus.bp_choice, e.taken);
        check("pop_clear",  bus.bp_clear,  e.miss);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    idle();
    bus.pc_insert_req = 1'b0;
    bus.pc_insert_mux = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    sample();
    check("rst_rob_ready", bus.rob_ready, 1'b1);
    check("rst_pc_stall",  bus.pc_stall, 1'b0);
    check("rst_modify",    bus.bp_modify_en, 1'b0);
    check("rst_clear",     bus.bp_clear, 1'b0);
    check("rst_insert",    bus.bp_insert_en, 1'b0);
    check("rst_branches",  stat_branches, 0);
    check("rst_misses",    stat_misses, 0);

    // Two clean commits drain in order, one per cycle, no bypass
    next();
    commit(1, 1, 0, 1, 0, 0, 1);
    bus.pc_insert_req = 1'b1;
    bus.pc_insert_mux = 1'b1;
    sample();
    check("t1_no_bypass", bus.bp_modify_en, 1'b0);
    check("t1_insert",    bus.bp_insert_en, 1'b1);
    check("t1_mux_hi",    bus.bp_mux, 1'b1);
    check("t1_ready0",    bus.rob_ready, 1'b1);
    next();
    sample();
    check("t1_modify1", bus.bp_modify_en, 1'b1);
    check("t1_ready1",  bus.rob_ready, 1'b1);
    next();
    bus.pc_insert_mux = 1'b0;
    sample();
    check("t1_modify2", bus.bp_modify_en, 1'b1);
    check("t1_mux_lo",  bus.bp_mux, 1'b0);
    next();
    bus.pc_insert_req = 1'b0;
    sample();
    check("t1_idle",     bus.bp_modify_en, 1'b0);
    check("t1_branches", stat_branches, 2);
    check("t1_misses",   stat_misses, 0);
    check("t1_ready3",   bus.rob_ready, 1'b1);

    // Fill: rob_ready drops at count 3 and commits offered then are ignored
    next();
    commit(1, 1, 0, 1, 0, 0, 1);
    sample();
    check("t2_ready_c0", bus.rob_ready, 1'b1);
    next();
    commit(1, 1, 0, 1, 1, 0, 1);
    sample();
    check("t2_ready_c1", bus.rob_ready, 1'b1);
    next();
    commit(1, 0, 0, 1, 0, 0, 0);
    sample();
    check("t2_ready_full", bus.rob_ready, 1'b0);
    next();
    sample();
    check("t2_ready_c3", bus.rob_ready, 1'b1);
    drain();
    next();
    sample();
    check("t2_drain_idle", bus.bp_modify_en, 1'b0);
    check("t2_branches",   stat_branches, 6);

    // Mispredict on commit1 drops commit2; clear then 2 recover cycles
    bus.pc_insert_req = 1'b1;
    next();
    commit(1, 1, 1, 1, 0, 0, 1);
    sample();
    check("t3_pre_stall",  bus.pc_stall, 1'b0);
    check("t3_pre_insert", bus.bp_insert_en, 1'b1);
    next();
    sample();
    check("t3_clr_modify", bus.bp_modify_en, 1'b1);
    check("t3_clr_clear",  bus.bp_clear, 1'b1);
    check("t3_clr_stall",  bus.pc_stall, 1'b1);
    check("t3_clr_insert", bus.bp_insert_en, 1'b0);
    for (int i = 0; i < 2; i++) begin
      next();
      sample();
      check("t3_rec_stall",  bus.pc_stall, 1'b1);
      check("t3_rec_insert", bus.bp_insert_en, 1'b0);
      check("t3_rec_modify", bus.bp_modify_en, 1'b0);
    end
    next();
    sample();
    check("t3_end_stall",  bus.pc_stall, 1'b0);
    check("t3_end_insert", bus.bp_insert_en, 1'b1);
    check("t3_end_modify", bus.bp_modify_en, 1'b0);
    check("t3_misses",     stat_misses, 1);
    check("t3_branches",   stat_branches, 7);

    // Queued miss behind a clean head stalls; later clean entry waits for recovery
    next();
    commit(1, 1, 0, 1, 0, 1, 1);
    next();
    commit(1, 1, 0, 0, 0, 0, 1);
    sample();
    check("t4_head_clean_modify", bus.bp_modify_en, 1'b1);
    check("t4_head_clean_clear",  bus.bp_clear, 1'b0);
    check("t4_pending_stall",     bus.pc_stall, 1'b1);
    check("t4_pending_insert",    bus.bp_insert_en, 1'b0);
    next();
    sample();
    check("t4_clr_clear", bus.bp_clear, 1'b1);
    check("t4_clr_stall", bus.pc_stall, 1'b1);
    for (int i = 0; i < 2; i++) begin
      next();
      sample();
      check("t4_rec_modify", bus.bp_modify_en, 1'b0);
      check("t4_rec_stall",  bus.pc_stall, 1'b1);
    end
    next();
    sample();
    check("t4_after_modify", bus.bp_modify_en, 1'b1);
    check("t4_after_stall",  bus.pc_stall, 1'b0);
    check("t4_after_insert", bus.bp_insert_en, 1'b1);
    next();
    sample();
    check("t4_branches", stat_branches, 10);
    check("t4_misses",   stat_misses, 2);

    // rdy low for 3 cycles mid-recovery freezes everything
    next();
    commit(1, 0, 1, 0, 0, 0, 1);
    next();
    commit(1, 1, 0, 0, 0, 0, 1);
    sample();
    check("t5_clear", bus.bp_clear, 1'b1);
    for (int i = 0; i < 3; i++) begin
      next();
      rdy = 1'b0;
      commit(1, 0, 0, 1, 0, 0, 0);
      sample();
      check("t5_frz_ready",  bus.rob_ready, 1'b0);
      check("t5_frz_modify", bus.bp_modify_en, 1'b0);
      check("t5_frz_insert", bus.bp_insert_en, 1'b0);
      check("t5_frz_stall",  bus.pc_stall, 1'b1);
    end
    next();
    rdy = 1'b1;
    sample();
    check("t5_ret_stall",    bus.pc_stall, 1'b1);
    check("t5_ret_modify",   bus.bp_modify_en, 1'b0);
    check("t5_ret_ready",    bus.rob_ready, 1'b1);
    check("t5_ret_branches", stat_branches, 11);
    next();
    sample();
    check("t5_rec2_stall",  bus.pc_stall, 1'b1);
    check("t5_rec2_modify", bus.bp_modify_en, 1'b0);
    next();
    sample();
    check("t5_end_stall",  bus.pc_stall, 1'b0);
    check("t5_end_modify", bus.bp_modify_en, 1'b1);
    check("t5_end_insert", bus.bp_insert_en, 1'b1);
    next();
    sample();
    check("t5_branches", stat_branches, 12);
    check("t5_misses",   stat_misses, 3);

    // Reset while recovering with 3 entries queued discards everything
    next();
    commit(1, 0, 1, 0, 0, 0, 1);
    next();
    commit(1, 1, 0, 1, 0, 0, 1);
    sample();
    check("t6_clear", bus.bp_clear, 1'b1);
    next();
    commit(1, 1, 0, 0, 0, 0, 1);
    sample();
    check("t6_ready_c2", bus.rob_ready, 1'b1);
    next();
    rst = 1'b1;
    exp_q.delete();
    sample();
    check("t6_pre_ready",    bus.rob_ready, 1'b0);
    check("t6_pre_stall",    bus.pc_stall, 1'b1);
    check("t6_pre_branches", stat_branches, 13);
    next();
    rst = 1'b0;
    sample();
    check("t6_post_ready",    bus.rob_ready, 1'b1);
    check("t6_post_stall",    bus.pc_stall, 1'b0);
    check("t6_post_modify",   bus.bp_modify_en, 1'b0);
    check("t6_post_branches", stat_branches, 0);
    check("t6_post_misses",   stat_misses, 0);
    repeat (3) next();
    sample();
    check("t6_empty_modify", bus.bp_modify_en, 1'b0);
    check("t6_empty_insert", bus.bp_insert_en, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/predictor_update_ctrl.md
Name: predictor_update_ctrl

Overview:
Sits between the ROB, the PC unit and the global-history branch predictor.
- Buffers resolved-branch outcomes from the ROB (up to 2 per cycle) and drains them into the predictor's single update port, one per cycle, in commit order.
- Sequences mispredict recovery: asserts the predictor's history restore (clear), then holds off speculative history inserts from the PC for a fixed recovery window.
- Keeps branch/mispredict statistics counters.

Parameters:
DEPTH, 4, outcome-queue entries (power of 2, >= 2)
RECOVER_CYCLES, 2, cycles of insert blocking after a clear (>= 1)
CNT_WIDTH, 32, width of statistics counters

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  synchronous, active-high reset
rdy  in  1  global ready; when low all state frozen and all enables forced 0
rob_commit1_en  in  1  first committed branch valid
rob_commit1_taken  in  1  first branch actual direction
rob_commit1_miss  in  1  first branch was mispredicted
rob_commit2_en  in  1  second committed branch valid (younger than first)
rob_commit2_taken  in  1  second branch actual direction
rob_commit2_miss  in  1  second branch was mispredicted
rob_ready  out  1  queue can accept 2 pushes this cycle
pc_insert_req  in  1  PC requests speculative history insert
pc_insert_mux  in  1  PC slot select for the insert
pc_stall  out  1  PC must hold fetch/insert this cycle
bp_insert_en  out  1  to predictor insert_en
bp_mux  out  1  to predictor mux (passthrough of pc_insert_mux)
bp_modify_en  out  1  to predictor modify_en
bp_clear  out  1  to predictor clear
bp_choice  out  1  to predictor choice (actual direction)
stat_branches  out  CNT_WIDTH  branches retired into predictor
stat_misses  out  CNT_WIDTH  mispredicts retired into predictor

Behaviour:
- Reset: queue empty, pointers 0, state RUN, recover counter 0, stat counters 0.
  - Outputs after reset: rob_ready=1, pc_stall=0, all bp_* enables 0.
  - rst mid-RECOVER or with a non-empty queue discards everything.
- Queue entry = {taken, miss}. Occupancy count is 0..DEPTH.
  - rob_ready = rdy && (DEPTH - count >= 2), computed combinationally from registered state.
  - ROB may assert commit enables only when rob_ready=1; enables while rob_ready=0 are ignored.
- Push order is commit1 then commit2.
  - commit1_en && commit1_miss: commit2 is dropped (younger branch is on the wrong path).
  - commit2_en without commit1_en: pushed as a single entry.
- No bypass: an entry pushed in cycle N reaches the head no earlier than cycle N+1.
- Pop (combinational outputs, registered pop) occurs when rdy && state==RUN && count>0:
  - bp_modify_en=1, bp_choice=head.taken, bp_clear=head.miss.
  - Head advances at the clock edge.
  - Push and pop may occur in the same cycle: count_next = count + pushes - pop.
  - Pointers wrap modulo DEPTH.
- FSM:
  - RUN: pop as above. Popping an entry with miss=1 moves to RECOVER, with recover counter loaded to RECOVER_CYCLES-1.
  - RECOVER: no pops, pc_stall=1. Counter decrements each rdy cycle; the state returns to RUN after the cycle in which counter==0. This gives exactly RECOVER_CYCLES blocked cycles after the clear cycle.
- pc_stall = state==RECOVER || (bp_modify_en && bp_clear) || miss_pending.
  - miss_pending = any queued entry has miss=1. Track it with a counter of queued misses; do not scan the queue.
- bp_insert_en = rdy && pc_insert_req && !pc_stall. An insert is therefore never issued in the same cycle as a clear.
- bp_mux = pc_insert_mux unconditionally.
- Stat counters (per pop, wrap modulo 2^CNT_WIDTH):
  - stat_branches +1 on each pop.
  - stat_misses +1 on each pop with miss=1.
- rdy=0: no push, no pop, FSM and counters frozen, rob_ready=0, bp_modify_en=0, bp_insert_en=0. pc_stall keeps its state-derived value.

Decomposition:
- Shared defines header (alongside the existing width defines) holds:
  - entry field positions (ENTRY_TAKEN=0, ENTRY_MISS=1, entry width 2)
  - FSM encodings (ST_RUN=0, ST_RECOVER=1)
- One sub-module, bp_update_fifo: dual-push, single-pop circular queue.
  - Outputs count, head entry, miss_pending.
  - Controller holds the FSM, gating and statistics.

Test Plan:
- Reset, then push commit1{taken=1,miss=0} + commit2{taken=0,miss=0} in cycle 0 -> cycles 1,2: bp_modify_en=1, bp_choice=1 then 0, bp_clear=0; stat_branches=2 after cycle 2; rob_ready stays 1.
- Fill with DEPTH=4: push pairs in cycles 0 and 1 -> count reaches 3 at cycle 2 (one pop in cycle 1), so rob_ready=0 at cycle 2; commit enables asserted in cycle 2 are ignored (count unchanged).
- commit1{miss=1} with commit2_en=1 -> only one entry queued; at pop: bp_clear=1, bp_modify_en=1, pc_stall=1 in that cycle and for the next 2 cycles; pc_insert_req=1 throughout gives bp_insert_en=0 for those 3 cycles and 1 in the 4th; stat_misses=1.
- Clean entry queued behind a miss: while miss_pending, pc_stall=1 even though the head is clean; the clean entry pops only after RECOVER ends (cycle clear+3).
- Drop rdy for 3 cycles mid-RECOVER -> no outputs asserted; on rdy return the remaining recover cycles complete with an unchanged count.
- Assert rst while the queue holds 3 entries and state=RECOVER -> next cycle count=0, pc_stall=0, rob_ready=1, stats=0.
